segmented_incrementer: RTL and testbench

//   Pipelined, parametrised incrementer: result = operand + step, computed with one SEG_WIDTH carry segment per stage.

---
 rtl/segmented_incrementer_pkg.sv | 8 +
 rtl/segmented_incrementer_stage.sv | 61 ++++++
 rtl/segmented_incrementer.sv | 83 ++++++++
 tb/tb_segmented_incrementer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/segmented_incrementer_pkg.sv
// Shared definitions for the segmented incrementer: per-transaction mode encoding.
package segmented_incrementer_pkg;

  // Value of the saturate input / carried mode flag.
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/segmented_incrementer_stage.sv
// One pipeline stage of the segmented incrementer: resolves segment IDX of the
// operand by adding addend_i (step for segment 0, incoming carry otherwise) and
// registers the partially summed word, carry, mode flag and valid bit.
module incrementer_stage
  import segmented_incrementer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8,
  parameter int IDX       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 valid_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [SEG_WIDTH-1:0] addend_i,
  input  logic                 sat_i,
  output logic                 valid_o,
  output logic [WIDTH-1:0]     data_o,
  output logic                 carry_o,
  output logic                 sat_o
);

  localparam int LSB = IDX * SEG_WIDTH;

  logic [SEG_WIDTH:0] seg_sum;
  logic [WIDTH-1:0]   data_d;
  logic [WIDTH-1:0]   data_q;
  logic               valid_q;
  logic               carry_q;
  logic               sat_q;

  // Add into this stage's segment only; lower segments are already final and
  // upper segments pass through untouched until their own stage.
  always_comb begin
    seg_sum = {1'b0, data_i[LSB +: SEG_WIDTH]} + {1'b0, addend_i};
    data_d  = data_i;
    data_d[LSB +: SEG_WIDTH] = seg_sum[SEG_WIDTH-1:0];
  end

  // Stage register; whole pipe shares one enable so bubbles move in lockstep.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      carry_q <= 1'b0;
      sat_q   <= MODE_WRAP;
    end else if (en) begin
      valid_q <= valid_i;
      data_q  <= data_d;
      carry_q <= seg_sum[SEG_WIDTH];
      sat_q   <= sat_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign carry_o = carry_q;
  assign sat_o   = sat_q;

endmodule

// File: rtl/segmented_incrementer.sv
// Pipelined incrementer: result = operand + step, one SEG_WIDTH carry segment
// resolved per stage, with wrap/saturate per transaction and valid/ready flow.
module segmented_incrementer
  import segmented_incrementer_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SEG_WIDTH  = 8,
  parameter int STEP_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      operand,
  input  logic [STEP_WIDTH-1:0] step,
  input  logic                  saturate,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  overflow
);

  localparam int NSEG = WIDTH / SEG_WIDTH;

  if ((WIDTH % SEG_WIDTH) != 0 || STEP_WIDTH > SEG_WIDTH) begin : g_param_check
    $error("segmented_incrementer: WIDTH must be a multiple of SEG_WIDTH and STEP_WIDTH <= SEG_WIDTH");
  end

  logic             advance;
  logic             valid_s [0:NSEG];
  logic [WIDTH-1:0] data_s  [0:NSEG];
  logic             sat_s   [0:NSEG];
  logic             carry_s [1:NSEG];

  // The pipe only stalls when the output register holds a result nobody takes.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = operand;
  assign sat_s[0]   = saturate;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_WIDTH-1:0] addend;

    if (k == 0) begin : g_first
      assign addend = SEG_WIDTH'(step);
    end else begin : g_rest
      assign addend = SEG_WIDTH'(carry_s[k]);
    end

    incrementer_stage #(
      .WIDTH    (WIDTH),
      .SEG_WIDTH(SEG_WIDTH),
      .IDX      (k)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en      (advance),
      .valid_i (valid_s[k]),
      .data_i  (data_s[k]),
      .addend_i(addend),
      .sat_i   (sat_s[k]),
      .valid_o (valid_s[k+1]),
      .data_o  (data_s[k+1]),
      .carry_o (carry_s[k+1]),
      .sat_o   (sat_s[k+1])
    );
  end

  assign out_valid = valid_s[NSEG];
  assign overflow  = carry_s[NSEG];

  // Saturation is applied after the last carry is known; reset leaves data and
  // carry at zero, so result reads 0 out of reset.
  always_comb begin
    result = data_s[NSEG];
    if (overflow && (sat_s[NSEG] == MODE_SAT)) begin
      result = '1;
    end
  end

endmodule

// File: tb/tb_segmented_incrementer.sv
module tb_segmented_incrementer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] operand;
  logic [3:0]  step;
  logic        saturate;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;

  segmented_incrementer #(
    .WIDTH(32), .SEG_WIDTH(8), .STEP_WIDTH(4)
  ) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operand(operand), .step(step), .saturate(saturate),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit rnd_mode = 0;

  always @(posedge clk) cyc++;

  // random backpressure, only while rnd_mode is set
  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t sb[$];

  logic [31:0] exp_res;
  logic        exp_ovf;
  bit          exp_lat;

  typedef struct {
    logic [31:0] op;
    logic [3:0]  stp;
    logic        sat;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model(input logic [31:0] op, input logic [3:0] stp, input logic sat,
                                output logic [31:0] res, output logic ovf);
    logic [32:0] s;
    s   = {1'b0, op} + {29'd0, stp};
    ovf = s[32];
    res = (ovf && sat) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  // scoreboard: push on accept, pop/compare on transfer out
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output actual=%h/%b required=no_output (cycle %0d)", result, overflow, cyc);
      end else begin
        e = sb.pop_front();
        if (result !== e.res || overflow !== e.ovf) begin
          failures++;
          $display("FAIL result actual=%h ovf=%b required=%h ovf=%b (cycle %0d)",
                   result, overflow, e.res, e.ovf, cyc);
        end
        if (e.chk_lat) begin
          checks++;
          if (cyc - e.acc_cyc != 4) begin
            failures++;
            $display("FAIL latency actual=%0d required=4", cyc - e.acc_cyc);
          end
        end
      end
    end
    if (!reset && in_valid && in_ready) begin
      e.res = exp_res;
      e.ovf = exp_ovf;
      e.acc_cyc = cyc;
      e.chk_lat = exp_lat;
      sb.push_back(e);
    end
  end

  task automatic drive_op(input logic [31:0] op, input logic [3:0] stp, input logic sat,
                          input logic [31:0] er, input logic eo, input bit lat);
    bit acc;
    int n;
    in_valid = 1'b1;
    operand  = op;
    step     = stp;
    saturate = sat;
    exp_res  = er;
    exp_ovf  = eo;
    exp_lat  = lat;
    acc = 0;
    n = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && n > 200) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout actual=not_accepted required=accepted op=%h", op);
        acc = 1;
      end
    end
  endtask

  task automatic drive_model(input logic [31:0] op, input logic [3:0] stp, input logic sat, input bit lat);
    logic [31:0] r;
    logic        o;
    model(op, stp, sat, r, o);
    drive_op(op, stp, sat, r, o, lat);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{32'h0000_00FF, 4'h1, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1]  = '{32'hFFFF_FFFF, 4'h1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2]  = '{32'hFFFF_FFFF, 4'h1, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[3]  = '{32'h00FF_FFFF, 4'hF, 1'b0, 32'h0100_000E, 1'b0};
    vecs[4]  = '{32'h1234_5678, 4'h0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[5]  = '{32'h1234_5678, 4'h0, 1'b1, 32'h1234_5678, 1'b0};
    vecs[6]  = '{32'hFFFF_FFF0, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[7]  = '{32'hFFFF_FFF1, 4'hF, 1'b1, 32'hFFFF_FFFF, 1'b1};
    vecs[8]  = '{32'hFFFF_FFF1, 4'hF, 1'b0, 32'h0000_0000, 1'b1};
    vecs[9]  = '{32'h00FF_00FF, 4'h1, 1'b0, 32'h00FF_0100, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF, 4'h0, 1'b1, 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{32'h7FFF_FFFF, 4'h1, 1'b1, 32'h8000_0000, 1'b0};

    reset = 1'b1; in_valid = 1'b0; operand = '0; step = '0; saturate = 1'b0; out_ready = 1'b1;
    exp_res = '0; exp_ovf = 1'b0; exp_lat = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // table vectors, back-to-back, no backpressure, latency checked
    for (int i = 0; i < 12; i++)
      drive_op(vecs[i].op, vecs[i].stp, vecs[i].sat, vecs[i].res, vecs[i].ovf, 1);
    in_valid = 1'b0;
    drain();

    // back-to-back 0..4 step 4
    for (int i = 0; i < 5; i++)
      drive_op(32'(i), 4'd4, 1'b0, 32'(i + 4), 1'b0, 1);
    in_valid = 1'b0;
    drain();

    // fill pipe with output blocked, then stall 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      drive_op(32'h0000_10FF + 32'(i), 4'd1, 1'b0, 32'h0000_1100 + 32'(i), 1'b0, 0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_result", result, 32'h0000_1100);
      chk("stall_occupancy", 32'(sb.size()), 32'd4);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_op(32'hFFFF_FFFE, 4'd3, 1'b1, 32'hFFFF_FFFF, 1'b1, 0);
    in_valid = 1'b0;
    drain();

    // reset one cycle before first output: nothing may emerge
    drive_op(32'h0000_0001, 4'd1, 1'b0, 32'h0000_0002, 1'b0, 1);
    drive_op(32'h0000_0002, 4'd1, 1'b0, 32'h0000_0003, 1'b0, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;

    // random traffic with random backpressure and idle gaps
    rnd_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [31:0] op;
      case ($urandom_range(0, 2))
        0: op = $urandom;
        1: op = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: op = 32'h00FF_FFF0 | (32'($urandom_range(0, 3)) << 24) | 32'($urandom_range(0, 15));
      endcase
      drive_model(op, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
    rnd_mode = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
